// File: rtl/palette_layer_scheduler.sv
// Per-pixel sprite layer arbiter: picks the highest-priority opaque layer and looks up its colour in a shared palette.
// Define PAL_FASTSCAN_EN to resolve all layers in a single scan cycle with a priority encoder instead of one layer per cycle.
module palette_layer_scheduler #(
  parameter int                 NUM_LAYERS      = 4,
  parameter int                 IDX_W           = 4,
  parameter logic [IDX_W-1:0]   TRANSPARENT_IDX = '0,
  parameter int                 LW              = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        pix_start,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_index,
  output logic [IDX_W-1:0]            pal_index,
  input  logic [11:0]                 pal_rgb,
  output logic [3:0]                  red,
  output logic [3:0]                  green,
  output logic [3:0]                  blue,
  output logic                        pix_valid,
  output logic [LW-1:0]               win_layer,
  output logic                        win_none,
  output logic                        busy
);

  // state  | meaning
  // IDLE   | waiting for pix_start, layer snapshot captured on accept
  // SCAN   | searching for the first opaque layer
  // LOOKUP | palette index driven, colour registered at end of cycle
  // DONE   | pix_valid high for one cycle
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LOOKUP, S_DONE} state_t;

  state_t                      state_q;
  logic [NUM_LAYERS-1:0]       hit_q;
  logic [NUM_LAYERS*IDX_W-1:0] idx_q;
  logic [IDX_W-1:0]            pal_index_q;
  logic [3:0]                  red_q, green_q, blue_q;
  logic                        pix_valid_q;
  logic [LW-1:0]               win_layer_q;
  logic                        win_none_q;
  logic                        busy_q;

  logic [IDX_W-1:0]            idx_arr [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]       opaque;

  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      idx_arr[k] = idx_q[k*IDX_W +: IDX_W];
      opaque[k]  = hit_q[k] && (idx_q[k*IDX_W +: IDX_W] != TRANSPARENT_IDX);
    end
  end

`ifdef PAL_FASTSCAN_EN
  logic          fast_hit;
  logic [LW-1:0] fast_sel;

  // Descending loop so the lowest-numbered opaque layer is the last write and wins.
  always_comb begin
    fast_hit = 1'b0;
    fast_sel = '0;
    for (int k = NUM_LAYERS-1; k >= 0; k--) begin
      if (opaque[k]) begin
        fast_hit = 1'b1;
        fast_sel = LW'(k);
      end
    end
  end
`else
  logic [LW-1:0] ptr_q;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      hit_q       <= '0;
      idx_q       <= '0;
      pal_index_q <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      pix_valid_q <= 1'b0;
      win_layer_q <= '0;
      win_none_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifndef PAL_FASTSCAN_EN
      ptr_q       <= '0;
`endif
    end else begin
      pix_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pix_start) begin
            hit_q   <= layer_hit;
            idx_q   <= layer_index;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
`ifndef PAL_FASTSCAN_EN
            ptr_q   <= '0;
`endif
          end
        end
        S_SCAN: begin
`ifdef PAL_FASTSCAN_EN
          if (fast_hit) begin
            pal_index_q <= idx_arr[fast_sel];
            win_layer_q <= fast_sel;
            win_none_q  <= 1'b0;
          end else begin
            pal_index_q <= TRANSPARENT_IDX;
            win_layer_q <= '0;
            win_none_q  <= 1'b1;
          end
          state_q <= S_LOOKUP;
`else
          if (opaque[ptr_q]) begin
            pal_index_q <= idx_arr[ptr_q];
            win_layer_q <= ptr_q;
            win_none_q  <= 1'b0;
            state_q     <= S_LOOKUP;
          end else if (ptr_q == LW'(NUM_LAYERS-1)) begin
            pal_index_q <= TRANSPARENT_IDX;
            win_layer_q <= '0;
            win_none_q  <= 1'b1;
            state_q     <= S_LOOKUP;
          end else begin
            ptr_q <= ptr_q + LW'(1);
          end
`endif
        end
        S_LOOKUP: begin
          {red_q, green_q, blue_q} <= pal_rgb;
          pix_valid_q              <= 1'b1;
          state_q                  <= S_DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pal_index = pal_index_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign pix_valid = pix_valid_q;
  assign win_layer = win_layer_q;
  assign win_none  = win_none_q;
  assign busy      = busy_q;

endmodule
